path_player: RTL and testbench
==============================

# path_player

Replays a recorded maze path as a stream of grid positions. The solver pushes accepted move codes in forward order during the search; on `run`, this block walks them from the start cell (x=0, y=15) and emits one position per move over a valid/ready handshake. It then reports whether the walk ended on the goal cell (x=15, y=0). It is the reader for the solver's path record and drives the downstream display/robot port.

## Interface
- `DEPTH`, 64: move entries stored; power of two, at least 2.
- `W`, 4: coordinate width; the grid is 2^W by 2^W.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous flush to the empty IDLE state.
- `push` in 1: write `push_dir` into the record; honoured only in IDLE.
- `push_dir` in 2: move code. 0 = x-1, 1 = y-1, 2 = y+1, 3 = x+1.
- `run` in 1: start replay; honoured in IDLE or DONE.
- `out_ready` in 1: downstream accepts the current step.
- `out_valid` out 1: a step is presented.
- `out_x`, `out_y` out W: position after the presented move.
- `out_dir` out 2: the presented move code.
- `busy` out 1: high while in PLAY.
- `done` out 1: high while in DONE.
- `at_goal` out 1: meaningful in DONE; final position is (2^W-1, 0).
- `overflow` out 1: sticky; a push was dropped because the record was full.
- `clamped` out 1: sticky; a move was saturated at the grid edge.
- `count` out log2(DEPTH)+1: number of stored entries.

## Operation
- States are IDLE, PLAY and DONE. Reset puts the block in IDLE with:
  - all outputs 0, except `out_y` = 2^W-1;
  - `count` = 0;
  - position register = (0, 2^W-1).
- IDLE:
  - `push` with `count` < DEPTH writes mem[count] and increments `count`.
  - `push` with `count` = DEPTH drops the entry and sets `overflow`.
- Starting a replay:
  - `run` in IDLE or DONE resets position to (0, 2^W-1), resets the read pointer to 0, and enters PLAY.
  - If `count` = 0, the block goes directly to DONE with `at_goal` evaluated at the start cell. No steps are emitted.
- PLAY: the step for entry k presents
  - `out_dir` = mem[k];
  - `out_x`/`out_y` = the position after applying mem[k], using saturating arithmetic.
- Saturation: a decrement at 0 or an increment at 2^W-1 holds the coordinate and sets `clamped`.
- On a transfer (`out_valid` & `out_ready`):
  - position takes the presented value;
  - k increments;
  - after entry `count`-1 the block enters DONE.
- DONE:
  - `at_goal` = (pos_x == 2^W-1) & (pos_y == 0).
  - `out_x`/`out_y` hold the final position.
  - The record is retained, so `run` replays it again.
- `clear`, in any state:
  - goes to IDLE with `count` = 0;
  - clears `overflow`, `clamped`, `at_goal` and `out_valid`;
  - resets position.
  - `clear` wins over `run` and `push` in the same cycle.
- `push` outside IDLE is ignored. It does not set `overflow`.
- `push` and `run` in the same IDLE cycle: the push is stored and included in the replay. `count` is sampled after the write.

## Timing
- `run` at edge n gives `busy` = 1 and `out_valid` = 1 after edge n (first step visible in cycle n+1).
- Outputs are registered.
- One step is transferred per cycle at most, so full-rate replay of N moves takes N cycles.
- While `out_valid` & !`out_ready`, the outputs `out_x`, `out_y` and `out_dir` are held stable.
- `out_valid` is never deasserted without a transfer, except by `clear` or `rst`.
- After the last transfer, on the next edge: `out_valid` = 0, `busy` = 0, `done` = 1, and `at_goal` is valid in the same cycle as `done`.
- `rst` mid-PLAY aborts immediately, with no further transfer. The stored record is lost (`count` = 0).

## Structure
- Shared package holds:
  - move-code constants MV_XDEC = 0, MV_YDEC = 1, MV_YINC = 2, MV_XINC = 3;
  - start and goal coordinates;
  - the state enum.
- One sub-module, `move_step`: combinational saturating apply of a move code to (x, y). It outputs new x, new y and a clamp flag, and is reusable by the solver side.
- The record is a DEPTH×2 register array written at `count` and read at k. It has no reset on the array contents.

## Test plan
- Six pushes of 3,3,1,1,3,1, then `run` with `out_ready` = 1:
  - steps (1,15), (2,15), (2,14), (2,13), (3,13), (3,12);
  - `done` = 1 the cycle after the sixth step;
  - `at_goal` = 0.
- 15 pushes of 3 and 15 pushes of 1, then `run`:
  - 30 steps, the last at (15,0);
  - `at_goal` = 1 and `clamped` = 0.
- Single push of 0 (x-1 at x=0), then `run`:
  - step (0,15) with `out_dir` = 0;
  - `clamped` = 1.
- 65 pushes: `count` = 64 and `overflow` = 1. Then `run` with `out_ready` toggling 1/0:
  - exactly 64 transfers;
  - outputs stable during every stall cycle.
- `run` with `count` = 0: `done` = 1 the next cycle, `out_valid` never high, `at_goal` = 0.
- Mid-PLAY cases:
  - `clear` after 2 of 6 steps: `out_valid` = 0 next cycle, IDLE, `count` = 0.
  - `rst` asserted asynchronously mid-PLAY: all outputs return to their reset values with no clock edge.

Source files
------------

// File: rtl/path_player_pkg.sv
`default_nettype none
// ============================================================================
// Module   : path_player_pkg
// Purpose  : Shared definitions for the maze path replay block and its
//            solver-side users. Holds the move codes, the start/goal
//            coordinates and the replay state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package path_player_pkg;

   // Move codes as written by the solver
   localparam logic [1:0] MV_XDEC = 2'd0;
   localparam logic [1:0] MV_YDEC = 2'd1;
   localparam logic [1:0] MV_YINC = 2'd2;
   localparam logic [1:0] MV_XINC = 2'd3;

   // The start cell is the bottom-left corner (0, top) and the goal is the
   // top-right corner (top, 0). "top" depends on the grid width, so it comes
   // from top_coord().
   localparam int START_X = 0;
   localparam int GOAL_Y  = 0;

   function automatic int top_coord(input int w);
      return (1 << w) - 1;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/path_player_if.sv
`default_nettype none
// ============================================================================
// Module   : path_player_if
// Purpose  : Valid/ready step stream from the path replay block to the
//            downstream display/robot port.
// Signals  : out_valid - a step is presented
//            out_ready - downstream accepts the current step
//            out_x/y   - position after the presented move (W bits)
//            out_dir   - presented move code
// Revision : 1.0 - initial release
// ============================================================================
interface path_player_if #(
   parameter int W = 4
) ();
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_x;
   logic [W-1:0] out_y;
   logic [1:0]   out_dir;

   modport master (output out_valid, output out_x, output out_y,
                   output out_dir, input out_ready);
   modport slave  (input out_valid, input out_x, input out_y,
                   input out_dir, output out_ready);
endinterface
`default_nettype wire

// File: rtl/path_player_move_step.sv
`default_nettype none
// ============================================================================
// Module   : move_step
// Purpose  : Combinational saturating application of one move code to a
//            grid position. A move that would leave the grid holds the
//            coordinate and raises clamp.
// Ports    : dir   in  2 - move code
//            x, y  in  W - current position
//            new_x out W - position after the move
//            new_y out W
//            clamp out 1 - the move was saturated at a grid edge
// Revision : 1.0 - initial release
// ============================================================================
module move_step
   import path_player_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [1:0]   dir,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic [W-1:0] new_x,
   output logic [W-1:0] new_y,
   output logic         clamp
);
   localparam logic [W-1:0] ONE = W'(1);
   localparam logic [W-1:0] TOP = W'(top_coord(W));

   always_comb begin
      new_x = x;
      new_y = y;
      clamp = 1'b0;
      case (dir)
         MV_XDEC: if (x == '0)  clamp = 1'b1; else new_x = x - ONE;
         MV_YDEC: if (y == '0)  clamp = 1'b1; else new_y = y - ONE;
         MV_YINC: if (y == TOP) clamp = 1'b1; else new_y = y + ONE;
         MV_XINC: if (x == TOP) clamp = 1'b1; else new_x = x + ONE;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/path_player.sv
`default_nettype none
// ============================================================================
// Module   : path_player
// Purpose  : Stores the solver's move record and replays it from the start
//            cell as a valid/ready stream of positions, then reports whether
//            the walk ended on the goal cell.
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            clear         - synchronous flush to empty IDLE
//            push/push_dir - append a move code (IDLE only)
//            run           - start a replay (IDLE or DONE)
//            step_if       - step stream (master side)
//            busy/done     - PLAY / DONE state indicators
//            at_goal       - final position is the goal (valid in DONE)
//            overflow      - sticky, a push was dropped on a full record
//            clamped       - sticky, a move was saturated at the grid edge
//            count         - number of stored entries
// Revision : 1.0 - initial release
// ============================================================================
module path_player
   import path_player_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int W     = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic [1:0]               push_dir,
   input  logic                     run,
   path_player_if.master            step_if,
   output logic                     busy,
   output logic                     done,
   output logic                     at_goal,
   output logic                     overflow,
   output logic                     clamped,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   localparam logic [W-1:0]  START_XW = W'(START_X);
   localparam logic [W-1:0]  START_YW = W'(top_coord(W));
   localparam logic [W-1:0]  GOAL_XW  = W'(top_coord(W));
   localparam logic [W-1:0]  GOAL_YW  = W'(GOAL_Y);
   localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   // Move record; contents are deliberately not reset
   logic [1:0]    mem [DEPTH];

   state_t        state;
   logic [AW-1:0] rd_ptr;
   logic          cur_valid;
   logic [W-1:0]  cur_x;
   logic [W-1:0]  cur_y;
   logic [1:0]    cur_dir;

   logic          push_ok;
   logic          start;
   logic          xfer;
   logic          last;
   logic [AW:0]   count_after;
   logic [1:0]    first_dir;
   logic [AW-1:0] next_ptr;
   logic [W-1:0]  ms_x;
   logic [W-1:0]  ms_y;
   logic [1:0]    ms_dir;
   logic [W-1:0]  nx;
   logic [W-1:0]  ny;
   logic          nclamp;

   assign push_ok     = (state == ST_IDLE) && push && !clear && (count != FULL);
   assign start       = run && ((state == ST_IDLE) || (state == ST_DONE));
   assign xfer        = (state == ST_PLAY) && cur_valid && step_if.out_ready;
   assign last        = ({1'b0, rd_ptr} == (count - CNT_ONE));
   assign count_after = push_ok ? (count + CNT_ONE) : count;
   assign next_ptr    = rd_ptr + PTR_ONE;

   // A push in the same cycle as run on an empty record lands in entry 0,
   // so the first step must see it before it reaches the array.
   assign first_dir = (push_ok && (count == '0)) ? push_dir : mem[0];

   // One stepper serves both the first step (from the start cell) and every
   // following step (from the presented position, which a transfer commits).
   always_comb begin
      ms_x   = START_XW;
      ms_y   = START_YW;
      ms_dir = first_dir;
      if (state == ST_PLAY) begin
         ms_x   = cur_x;
         ms_y   = cur_y;
         ms_dir = mem[next_ptr];
      end
   end

   move_step #(.W(W)) u_move_step (
      .dir   (ms_dir),
      .x     (ms_x),
      .y     (ms_y),
      .new_x (nx),
      .new_y (ny),
      .clamp (nclamp)
   );

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[count[AW-1:0]] <= push_dir;
   end

   // The presented coordinates double as the position register: a transfer
   // commits exactly the presented value, and in IDLE/DONE they hold the
   // start or final cell.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         count     <= '0;
         rd_ptr    <= '0;
         cur_valid <= 1'b0;
         cur_x     <= START_XW;
         cur_y     <= START_YW;
         cur_dir   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         at_goal   <= 1'b0;
         overflow  <= 1'b0;
         clamped   <= 1'b0;
      end else if (clear) begin
         state     <= ST_IDLE;
         count     <= '0;
         rd_ptr    <= '0;
         cur_valid <= 1'b0;
         cur_x     <= START_XW;
         cur_y     <= START_YW;
         cur_dir   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         at_goal   <= 1'b0;
         overflow  <= 1'b0;
         clamped   <= 1'b0;
      end else begin
         count <= count_after;
         if ((state == ST_IDLE) && push && (count == FULL))
            overflow <= 1'b1;

         if (start) begin
            rd_ptr <= '0;
            if (count_after == '0) begin
               state     <= ST_DONE;
               cur_valid <= 1'b0;
               cur_x     <= START_XW;
               cur_y     <= START_YW;
               busy      <= 1'b0;
               done      <= 1'b1;
               at_goal   <= (START_XW == GOAL_XW) && (START_YW == GOAL_YW);
            end else begin
               state     <= ST_PLAY;
               cur_valid <= 1'b1;
               cur_x     <= nx;
               cur_y     <= ny;
               cur_dir   <= first_dir;
               busy      <= 1'b1;
               done      <= 1'b0;
               at_goal   <= 1'b0;
               if (nclamp)
                  clamped <= 1'b1;
            end
         end else if (xfer) begin
            if (last) begin
               state     <= ST_DONE;
               cur_valid <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b1;
               at_goal   <= (cur_x == GOAL_XW) && (cur_y == GOAL_YW);
            end else begin
               rd_ptr  <= next_ptr;
               cur_x   <= nx;
               cur_y   <= ny;
               cur_dir <= mem[next_ptr];
               if (nclamp)
                  clamped <= 1'b1;
            end
         end
      end
   end

   assign step_if.out_valid = cur_valid;
   assign step_if.out_x     = cur_x;
   assign step_if.out_y     = cur_y;
   assign step_if.out_dir   = cur_dir;

endmodule
`default_nettype wire

// File: tb/tb_path_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_path_player
// Purpose  : Self-checking bench for path_player: table-driven replay of a
//            short path plus directed multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_path_player;

   typedef struct {
      logic [1:0] dir;
      logic [3:0] ex;
      logic [3:0] ey;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       clear;
   logic       push;
   logic [1:0] push_dir;
   logic       run;
   logic       busy;
   logic       done;
   logic       at_goal;
   logic       overflow;
   logic       clamped;
   logic [6:0] count;

   int n_checks;
   int n_fail;

   vec_t tbl [6];

   path_player_if #(.W(4)) step_if ();

   path_player #(.DEPTH(64), .W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .push     (push),
      .push_dir (push_dir),
      .run      (run),
      .step_if  (step_if),
      .busy     (busy),
      .done     (done),
      .at_goal  (at_goal),
      .overflow (overflow),
      .clamped  (clamped),
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [1:0] d);
      push     = 1'b1;
      push_dir = d;
      tick();
      push     = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic start_run();
      run = 1'b1;
      tick();
      run = 1'b0;
   endtask

   initial begin
      logic [31:0] saved;
      logic        stalled;
      int          xfers;
      logic [3:0]  ex;
      logic [3:0]  ey;

      n_checks = 0;
      n_fail   = 0;

      tbl[0] = '{2'd3, 4'd1, 4'd15};
      tbl[1] = '{2'd3, 4'd2, 4'd15};
      tbl[2] = '{2'd1, 4'd2, 4'd14};
      tbl[3] = '{2'd1, 4'd2, 4'd13};
      tbl[4] = '{2'd3, 4'd3, 4'd13};
      tbl[5] = '{2'd1, 4'd3, 4'd12};

      rst = 1'b1; clear = 1'b0; push = 1'b0; push_dir = 2'd0; run = 1'b0;
      step_if.out_ready = 1'b0;
      tick(); tick();
      check("rst_valid", step_if.out_valid, 0);
      check("rst_x", step_if.out_x, 0);
      check("rst_y", step_if.out_y, 15);
      check("rst_count", count, 0);
      check("rst_busy_done_goal", {busy, done, at_goal, overflow, clamped}, 0);
      rst = 1'b0;
      tick();

      // Six-move path, full rate
      for (int i = 0; i < 6; i++) push_one(tbl[i].dir);
      check("count6", count, 6);
      step_if.out_ready = 1'b1;
      start_run();
      for (int i = 0; i < 6; i++) begin
         check("p6_valid", step_if.out_valid, 1);
         check("p6_x", step_if.out_x, tbl[i].ex);
         check("p6_y", step_if.out_y, tbl[i].ey);
         check("p6_dir", step_if.out_dir, tbl[i].dir);
         tick();
      end
      check("p6_done", done, 1);
      check("p6_valid_off", step_if.out_valid, 0);
      check("p6_busy_off", busy, 0);
      check("p6_goal", at_goal, 0);
      check("p6_final", {step_if.out_x, step_if.out_y}, {4'd3, 4'd12});
      // Record retained: replay from DONE
      start_run();
      check("replay_first", {step_if.out_valid, busy, step_if.out_x, step_if.out_y}, {1'b1, 1'b1, 4'd1, 4'd15});
      step_if.out_ready = 1'b0;
      do_clear();
      check("clear_count", count, 0);

      // 30-move walk to the goal
      for (int i = 0; i < 15; i++) push_one(2'd3);
      for (int i = 0; i < 15; i++) push_one(2'd1);
      step_if.out_ready = 1'b1;
      start_run();
      for (int i = 0; i < 30; i++) begin
         ex = (i < 15) ? 4'(i + 1) : 4'd15;
         ey = (i < 15) ? 4'd15 : 4'(29 - i);
         check("g_step", {step_if.out_valid, step_if.out_x, step_if.out_y}, {1'b1, ex, ey});
         tick();
      end
      check("g_done", done, 1);
      check("g_goal", at_goal, 1);
      check("g_clamped", clamped, 0);

      // Push of x-1 together with run on an empty record
      do_clear();
      step_if.out_ready = 1'b0;
      push = 1'b1; push_dir = 2'd0; run = 1'b1;
      tick();
      push = 1'b0; run = 1'b0;
      check("c_count", count, 1);
      check("c_step", {step_if.out_valid, step_if.out_x, step_if.out_y, step_if.out_dir}, {1'b1, 4'd0, 4'd15, 2'd0});
      check("c_clamped", clamped, 1);
      step_if.out_ready = 1'b1;
      tick();
      check("c_done", {done, at_goal}, {1'b1, 1'b0});

      // Overflow and stalled replay
      do_clear();
      check("o_flags_cleared", {overflow, clamped}, 0);
      step_if.out_ready = 1'b0;
      for (int i = 0; i < 65; i++) push_one(2'd3);
      check("o_count", count, 64);
      check("o_overflow", overflow, 1);
      start_run();
      xfers   = 0;
      stalled = 1'b0;
      saved   = '0;
      for (int c = 0; c < 400; c++) begin
         if (done) break;
         if (stalled)
            check("o_stall_hold", {step_if.out_valid, step_if.out_x, step_if.out_y, step_if.out_dir}, saved);
         step_if.out_ready = (c % 2) == 1;
         if (step_if.out_valid && !step_if.out_ready) begin
            saved   = {21'd0, step_if.out_valid, step_if.out_x, step_if.out_y, step_if.out_dir};
            stalled = 1'b1;
         end else begin
            stalled = 1'b0;
         end
         if (step_if.out_valid && step_if.out_ready) xfers++;
         tick();
      end
      check("o_xfers", xfers, 64);
      check("o_done", done, 1);

      // Empty replay
      do_clear();
      start_run();
      check("e_done", {done, step_if.out_valid, at_goal, busy}, {1'b1, 1'b0, 1'b0, 1'b0});
      tick();
      check("e_valid_low", step_if.out_valid, 0);

      // clear mid-PLAY after two transfers
      do_clear();
      for (int i = 0; i < 6; i++) push_one(tbl[i].dir);
      step_if.out_ready = 1'b1;
      start_run();
      tick(); tick();
      check("m_third_step", {step_if.out_x, step_if.out_y}, {tbl[2].ex, tbl[2].ey});
      do_clear();
      check("m_clear", {step_if.out_valid, busy, done}, 0);
      check("m_clear_count", count, 0);

      // Asynchronous reset mid-PLAY
      for (int i = 0; i < 6; i++) push_one(tbl[i].dir);
      start_run();
      tick();
      check("r_playing", {busy, step_if.out_valid}, {1'b1, 1'b1});
      #2 rst = 1'b1;
      #1;
      check("r_async_valid_busy", {step_if.out_valid, busy, done}, 0);
      check("r_async_count", count, 0);
      check("r_async_pos", {step_if.out_x, step_if.out_y, step_if.out_dir}, {4'd0, 4'd15, 2'd0});
      rst = 1'b0;
      tick();
      check("r_after", {step_if.out_valid, count}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
